// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO unit: MULT/MULTU/DIV/DIVU over one shared 33-bit adder, plus MTHI/MTLO.
// Fixed 35-cycle latency from the start edge to the done pulse.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t      state_q, state_d;
    logic        is_div_q, is_signed_q, sign_a_q, sign_b_q;
    logic [31:0] opa_q, opb_q;
    logic [63:0] acc_q;
    logic [4:0]  cnt_q;

    logic        idle_like;
    logic [31:0] mag_a, mag_b;
    logic [31:0] add_x, add_y;
    logic        add_cin;
    logic [32:0] sum;
    logic        no_borrow;
    logic [63:0] iter_next;
    logic        negate;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign busy      = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
    assign done      = (state_q == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: next state gets its default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = (start && !op[2]) ? PREP : IDLE;
            PREP:       state_d = cancel ? IDLE : ITER;
            ITER:       state_d = cancel ? IDLE : ((cnt_q == 5'd0) ? FIX : ITER);
            FIX:        state_d = cancel ? IDLE : DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Operands were latched raw; signed ops take magnitudes during PREP.
    assign mag_a = (is_signed_q && sign_a_q) ? (32'd0 - opa_q) : opa_q;
    assign mag_b = (is_signed_q && sign_b_q) ? (32'd0 - opb_q) : opb_q;

    // Shared adder: multiply adds the multiplicand to the upper half; divide
    // subtracts the divisor from the shifted remainder (carry-out = no borrow).
    always_comb begin
        if (is_div_q) begin
            add_x   = acc_q[62:31];
            add_y   = ~opb_q;
            add_cin = 1'b1;
        end else begin
            add_x   = acc_q[63:32];
            add_y   = acc_q[0] ? opa_q : 32'd0;
            add_cin = 1'b0;
        end
    end

    assign sum       = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
    // A remainder bit shifted out above bit 31 already exceeds any 32-bit divisor.
    assign no_borrow = acc_q[63] | sum[32];
    assign iter_next = is_div_q
                     ? {(no_borrow ? sum[31:0] : acc_q[62:31]), acc_q[30:0], no_borrow}
                     : {sum, acc_q[31:1]};

    // Zero divisor leaves the quotient all ones unsigned; the remainder sign rule
    // then reproduces a in HI.
    assign negate   = is_signed_q && (sign_a_q ^ sign_b_q);
    assign prod_fix = negate ? (64'd0 - acc_q) : acc_q;
    assign quot_fix = (negate && (opb_q != 32'd0)) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem_fix  = (is_signed_q && sign_a_q) ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi          <= 32'd0;
            lo          <= 32'd0;
            cnt_q       <= 5'd0;
            acc_q       <= 64'd0;
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end else if (!op[2]) begin
                            opa_q       <= a;
                            opb_q       <= b;
                            is_div_q    <= op[1];
                            is_signed_q <= ~op[0];
                            sign_a_q    <= a[31] & ~op[0];
                            sign_b_q    <= b[31] & ~op[0];
                        end
                    end
                end
                PREP: begin
                    opa_q <= mag_a;
                    opb_q <= mag_b;
                    acc_q <= {32'd0, (is_div_q ? mag_a : mag_b)};
                    cnt_q <= 5'd31;
                end
                ITER: begin
                    acc_q <= iter_next;
                    cnt_q <= cnt_q - 5'd1;
                end
                FIX: begin
                    if (!cancel) begin
                        if (is_div_q) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, corner divides, cancel, reset, ignored starts.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, cancel;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
    localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge of cycle 1 with start dropped.
    task automatic launch(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic await_done(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                              input bit disturb);
        int cyc = 1;
        int busy_bad = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy !== 1'b1) busy_bad++;
            if (disturb && cyc >= 3 && cyc <= 10) begin
                start = 1'b1; op = MULTU; a = 32'd5; b = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_cmp++; if (cyc !== 35) begin n_bad++; $display("FAIL %s latency: got %0d want 35", name, cyc); end
        n_cmp++; if (busy_bad !== 0) begin n_bad++; $display("FAIL %s busy_window: %0d low cycles want 0", name, busy_bad); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_in_done: got %b want 0", name, busy); end
        n_cmp++; if (hi !== exp_hi) begin n_bad++; $display("FAIL %s hi: got %h want %h", name, hi, exp_hi); end
        n_cmp++; if (lo !== exp_lo) begin n_bad++; $display("FAIL %s lo: got %h want %h", name, lo, exp_lo); end
    endtask

    task automatic count_no_done(input string name, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL %s stray_done: got %0d pulses want 0", name, pulses); end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", done); end
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset lo: got %h want 0", lo); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult;
        launch(MULT, 32'hFFFF_FFFD, 32'd5);
        await_done("mult_neg3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mult done_pulse: got %b want 0", done); end
    endtask

    task automatic test_back_to_back;
        launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        await_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        launch(MULT, 32'd7, 32'hFFFF_FFFF);
        await_done("b2b_mult_7xm1", 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0);
    endtask

    task automatic test_div;
        launch(DIV, 32'hFFFF_FFF9, 32'd2);
        await_done("div_m7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    endtask

    task automatic test_div_corners;
        launch(DIVU, 32'd7, 32'd0);
        await_done("divu_by0", 32'd7, 32'hFFFF_FFFF, 1'b0);
        launch(DIV, 32'hFFFF_FFF9, 32'd0);
        await_done("div_neg_by0", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
        launch(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        await_done("div_overflow", 32'd0, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_cancel;
        @(negedge clk);
        start = 1'b1; op = MTLO; a = 32'h1234;
        @(negedge clk);
        op = MTHI; a = 32'hABCD;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (lo !== 32'h1234) begin n_bad++; $display("FAIL mtlo lo: got %h want 1234", lo); end
        n_cmp++; if (hi !== 32'hABCD) begin n_bad++; $display("FAIL mthi hi: got %h want abcd", hi); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mtx busy: got %b want 0", busy); end
        launch(DIVU, 32'd100, 32'd3);
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cancel busy: got %b want 0", busy); end
        count_no_done("cancel", 40);
        n_cmp++; if (hi !== 32'hABCD) begin n_bad++; $display("FAIL cancel hi: got %h want abcd", hi); end
        n_cmp++; if (lo !== 32'h1234) begin n_bad++; $display("FAIL cancel lo: got %h want 1234", lo); end
    endtask

    task automatic test_undef_op;
        start = 1'b1; op = 3'b110; a = 32'hDEAD_BEEF; b = 32'd1;
        @(negedge clk);
        op = 3'b111;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL undef busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'hABCD) begin n_bad++; $display("FAIL undef hi: got %h want abcd", hi); end
        n_cmp++; if (lo !== 32'h1234) begin n_bad++; $display("FAIL undef lo: got %h want 1234", lo); end
        count_no_done("undef", 5);
    endtask

    task automatic test_start_while_busy;
        launch(DIVU, 32'd100, 32'd3);
        await_done("busy_start_divu", 32'd1, 32'd33, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_iter;
        launch(MULT, 32'd3, 32'd3);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL midreset hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL midreset lo: got %h want 0", lo); end
        count_no_done("midreset", 40);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_div_corners();
        test_cancel();
        test_undef_op();
        test_start_while_busy();
        test_reset_mid_iter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller for the MIPS HI/LO unit: executes MULT, MULTU, DIV, DIVU iteratively on one shared 32-bit add/subtract path plus one-bit shifts, and services MTHI and MTLO directly. Sits beside the ALU in EX. The pipeline stalls on `busy` and reads `hi` and `lo` directly for MFHI and MFLO. Signed operations run on magnitudes, with a single sign-fix cycle at the end.

## Interface
Parameters:
- none (datapath fixed at 32 bits; iteration count fixed at 32)

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- `a`  in  32  rs operand (multiplicand or dividend; MTHI/MTLO source)
- `b`  in  32  rt operand (multiplier or divisor)
- `cancel`  in  1  exception flush; aborts an in-flight operation
- `busy`  out  1  high in PREP, ITER, FIX
- `done`  out  1  one-cycle pulse in DONE
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- Reset (`reset`=0 at an edge), from any state:
  - state goes to IDLE
  - `hi` and `lo` = 0, `busy` = 0, `done` = 0
  - iteration counter = 0
- IDLE/DONE with `start`=1:
  - op 000–011: latch `a`, `b`, op and signs; go to PREP.
  - MTHI or MTLO: write `a` to `hi` or `lo` at that edge; go to IDLE; no busy, no done.
  - Undefined op: go to IDLE.
- IDLE/DONE with `start`=0: DONE goes to IDLE; IDLE holds.
- PREP (1 cycle):
  - Signed ops: replace operands by their two's-complement magnitudes.
  - Clear the 64-bit accumulator, load the working operand, set counter to 31.
- ITER (32 cycles), one step per cycle through the shared 33-bit add/subtract:
  - Multiply: shift-add, LSB-first.
  - Divide: restoring shift-subtract; the quotient bit is 1 when the trial subtraction does not borrow.
  - The counter decrements each cycle; leave ITER at counter 0.
- FIX (1 cycle):
  - Signed multiply: negate the 64-bit product when sign(a) ≠ sign(b).
  - Signed divide: negate the quotient when sign(a) ≠ sign(b); the remainder takes the sign of `a`.
  - Write {HI,LO} at the end of FIX, then go to DONE.
- Divide by zero:
  - Divide by zero is not trapped.
  - DIVU: LO = 0xFFFFFFFF, HI = a.
  - DIV: LO = 0xFFFFFFFF, HI = a, with no sign fix applied.
- DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wraps, no flag).
- `cancel`=1 in PREP, ITER or FIX: go to IDLE at that edge, leave HI/LO unchanged, no `done`. `cancel` is ignored in IDLE and DONE.
- Priority: `reset` > `cancel` > `start`.
- `start` while `busy` is ignored; operands are not re-sampled.

## Timing
- Edge 0 samples `start` (MULT/DIV class).
- Cycles 1 to 34 are PREP (1), ITER (32) and FIX (1). `busy` is high during cycles 1 to 34.
- HI/LO update at edge 35; `done` is high during cycle 35 only.
- A new `start` in cycle 35 is accepted, giving back-to-back operations with one-cycle spacing and no IDLE gap.
- Total latency is 35 cycles from the start edge to `done`, identical for all four ops and all operand values.
- MTHI/MTLO: the register is visible the cycle after the start edge; `busy` stays 0.
- `hi` and `lo` are registered outputs and stay stable except at the edge ending FIX or an MTHI/MTLO edge.

## Test plan
- Signed multiply: MULT a=0xFFFFFFFD (−3), b=5 → `done` at cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFF1; `busy` high exactly cycles 1–34.
- Unsigned multiply and back-to-back issue: MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Follow with MULT 7×(−1) issued in the `done` cycle → hi=0xFFFFFFFF, lo=0xFFFFFFF9.
- Signed divide: DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide corner cases:
  - DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Cancel: MTLO a=0x1234 then MTHI a=0xABCD. Start DIVU 100/3 and assert `cancel` in ITER cycle 10 → IDLE next cycle, no `done`, hi=0xABCD, lo=0x1234.
- Reset and ignored start:
  - `reset`=0 mid-ITER → next cycle busy=0, hi=lo=0.
  - `start` with op=110 → no state change.
  - `start` while busy → result equals the first operation's result.
